// File: rtl/imm_pkg.sv
// Shared definitions for the immediate extender: format encodings and field bit positions.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_B  = 3'b000,
    IMM_I  = 3'b001,
    IMM_D  = 3'b010,
    IMM_CB = 3'b011,
    IMM_IW = 3'b100
  } imm_fmt_e;

  localparam int unsigned B_MSB  = 25;
  localparam int unsigned I_MSB  = 21;
  localparam int unsigned I_LSB  = 10;
  localparam int unsigned D_MSB  = 20;
  localparam int unsigned D_LSB  = 12;
  localparam int unsigned CB_MSB = 23;
  localparam int unsigned CB_LSB = 5;
  localparam int unsigned IW_MSB = 20;
  localparam int unsigned IW_LSB = 5;
  localparam int unsigned HW_MSB = 22;
  localparam int unsigned HW_LSB = 21;

endpackage

// File: rtl/imm_decode.sv
// Combinational decode of the 26-bit immediate field into a DATA_W-wide extended value.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [25:0]       imm26,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] imm,
  output logic              err
);

  logic [5:0] shamt;

  // Halfword select scales to a shift of 0, 16, 32 or 48.
  assign shamt = {imm26[HW_MSB:HW_LSB], 4'b0000};

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (ctrl)
      IMM_B:  imm = {{(DATA_W - 28){imm26[B_MSB]}}, imm26, 2'b00};
      IMM_I:  imm = {{(DATA_W - 12){1'b0}}, imm26[I_MSB:I_LSB]};
      IMM_D:  imm = {{(DATA_W - 9){imm26[D_MSB]}}, imm26[D_MSB:D_LSB]};
      IMM_CB: imm = {{(DATA_W - 21){imm26[CB_MSB]}}, imm26[CB_MSB:CB_LSB], 2'b00};
      IMM_IW: imm = {{(DATA_W - 16){1'b0}}, imm26[IW_MSB:IW_LSB]} << shamt;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender: decodes at the input and queues results in a DEPTH-entry
// valid/ready FIFO, flagging and counting illegal format codes.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       Imm26,
  input  logic [2:0]        Ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] BusImm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_err;
  logic              push, pop;

  imm_decode #(
    .DATA_W(DATA_W)
  ) u_decode (
    .imm26(Imm26),
    .ctrl (Ctrl),
    .imm  (dec_imm),
    .err  (dec_err)
  );

  // Ready depends only on stored occupancy, so a full FIFO refuses input even while popping.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign BusImm    = mem_q[rd_ptr_q].imm;
  assign out_tag   = mem_q[rd_ptr_q].tag;
  assign out_err   = mem_q[rd_ptr_q].err;
  assign err_count = err_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    if (push && dec_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      if (push) mem_q[wr_ptr_q] <= '{imm: dec_imm, tag: in_tag, err: dec_err};
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (DATA_W=64, DEPTH=2, TAG_W=5, CNT_W=2).
module tb_imm_extend_pipe;

  localparam int DEPTH = 2;
  localparam int ERR_MAX = 3;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [25:0] imm26;
  logic [2:0]  ctrl;
  logic [4:0]  in_tag, out_tag;
  logic [63:0] bus_imm;
  logic [1:0]  err_count;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t mq[$];
  int   merr;
  int   n_cmp = 0;
  int   n_bad = 0;

  imm_extend_pipe #(
    .DATA_W(64), .DEPTH(DEPTH), .TAG_W(5), .CNT_W(2)
  ) dut (
    .CLK      (clk),
    .Reset_n  (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Imm26    (imm26),
    .Ctrl     (ctrl),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .BusImm   (bus_imm),
    .out_tag  (out_tag),
    .out_err  (out_err),
    .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference extension from the format rules, using signed integer arithmetic.
  function automatic exp_t ref_entry(logic [25:0] i, logic [2:0] c, logic [4:0] t);
    exp_t    e;
    longint  u, s;
    longint unsigned f, hw;
    e.tag = t; e.err = 1'b0; e.imm = '0;
    u = longint'(i);
    case (c)
      3'd0: begin s = u; if (s >= (longint'(1) << 25)) s -= (longint'(1) << 26); e.imm = 64'(s * 4); end
      3'd1: e.imm = 64'((u >> 10) % 4096);
      3'd2: begin s = (u >> 12) % 512; if (s >= 256) s -= 512; e.imm = 64'(s); end
      3'd3: begin
        s = (u >> 5) % (longint'(1) << 19);
        if (s >= (longint'(1) << 18)) s -= (longint'(1) << 19);
        e.imm = 64'(s * 4);
      end
      3'd4: begin
        hw = 64'((u >> 21) % 4); f = 64'((u >> 5) % 65536);
        e.imm = f * (64'd1 << (16 * hw));
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Advance one clock, updating the reference queue from the inputs held across the edge.
  task automatic tick();
    bit   mpush, mpop;
    exp_t e;
    mpush = in_valid && (mq.size() < DEPTH);
    mpop  = out_ready && (mq.size() > 0);
    e = ref_entry(imm26, ctrl, in_tag);
    @(posedge clk);
    if (mpop) void'(mq.pop_front());
    if (mpush) begin
      mq.push_back(e);
      if (e.err && merr < ERR_MAX) merr++;
    end
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (bus_imm !== 64'd0) begin n_bad++; $display("FAIL reset_busimm: got %h want 0", bus_imm); end
    n_cmp++; if (out_tag !== 5'd0) begin n_bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_cmp++; if (err_count !== 2'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_directed();
    logic [25:0] di [3];
    logic [2:0]  dc [3];
    logic [63:0] dx [3];
    di[0] = 26'h3FFFFFF;                          dc[0] = 3'd0; dx[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    di[1] = {3'b000, 2'b11, 16'hBEEF, 5'b00000};  dc[1] = 3'd4; dx[1] = 64'hBEEF_0000_0000_0000;
    di[2] = 26'h100 << 12;                        dc[2] = 3'd2; dx[2] = 64'hFFFF_FFFF_FFFF_FF00;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; imm26 = di[k]; ctrl = dc[k]; in_tag = 5'(k + 7);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL directed%0d_valid: got %b want 1", k, out_valid); end
      n_cmp++; if (bus_imm !== dx[k]) begin n_bad++; $display("FAIL directed%0d_busimm: got %h want %h", k, bus_imm, dx[k]); end
      if (mq.size() > 0) begin
        n_cmp++; if (bus_imm !== mq[0].imm) begin n_bad++; $display("FAIL directed%0d_model: got %h want %h", k, bus_imm, mq[0].imm); end
        n_cmp++; if (out_tag !== mq[0].tag) begin n_bad++; $display("FAIL directed%0d_tag: got %h want %h", k, out_tag, mq[0].tag); end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; imm26 = 26'($urandom); ctrl = 3'd7; in_tag = 5'(k);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL illegal%0d_err: got %b want 1", k, out_err); end
      n_cmp++; if (bus_imm !== 64'd0) begin n_bad++; $display("FAIL illegal%0d_busimm: got %h want 0", k, bus_imm); end
      n_cmp++; if (err_count !== 2'(merr)) begin n_bad++; $display("FAIL illegal%0d_count: got %0d want %0d", k, err_count, merr); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int got[$];
    bit acc;
    out_ready = 1'b0; ctrl = 3'd1;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; imm26 = 26'($urandom); in_tag = 5'(k);
      tick();
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_tag !== 5'd1) begin n_bad++; $display("FAIL bp_head_tag: got %0d want 1", out_tag); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && out_ready) got.push_back(int'(out_tag));
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      if (mq.size() == 0 && !in_valid) break;
    end
    n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      n_cmp++; if (got[k] != k + 1) begin n_bad++; $display("FAIL bp_order%0d: got %0d want %0d", k, got[k], k + 1); end
    end
  endtask

  task automatic test_streaming();
    int nout = 0;
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (out_valid && out_ready) begin
        n_cmp++; if (out_tag !== 5'(nout)) begin n_bad++; $display("FAIL stream_tag: got %0d want %0d", out_tag, nout); end
        if (mq.size() > 0) begin
          n_cmp++; if (bus_imm !== mq[0].imm) begin n_bad++; $display("FAIL stream_busimm: got %h want %h", bus_imm, mq[0].imm); end
        end
        nout++;
      end
      if (i < 16) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; imm26 = 26'($urandom); ctrl = 3'($urandom_range(0, 4)); in_tag = 5'(i);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    n_cmp++; if (nout != 16) begin n_bad++; $display("FAIL stream_count: got %0d want 16", nout); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL rand_valid: got %b want %b", out_valid, mq.size() != 0); end
      n_cmp++; if (in_ready !== (mq.size() != DEPTH)) begin n_bad++; $display("FAIL rand_ready: got %b want %b", in_ready, mq.size() != DEPTH); end
      n_cmp++; if (err_count !== 2'(merr)) begin n_bad++; $display("FAIL rand_err_count: got %0d want %0d", err_count, merr); end
      if (mq.size() > 0) begin
        n_cmp++;
        if (bus_imm !== mq[0].imm || out_tag !== mq[0].tag || out_err !== mq[0].err) begin
          n_bad++;
          $display("FAIL rand_head: got %h/%h/%b want %h/%h/%b", bus_imm, out_tag, out_err,
                   mq[0].imm, mq[0].tag, mq[0].err);
        end
      end
      in_valid = ($urandom % 4) != 0; out_ready = ($urandom % 3) != 0;
      imm26 = 26'($urandom); ctrl = 3'($urandom); in_tag = 5'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    out_ready = 1'b0; ctrl = 3'd3;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; imm26 = 26'($urandom); in_tag = 5'(k + 20);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    mq.delete(); merr = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
    n_cmp++; if (err_count !== 2'd0) begin n_bad++; $display("FAIL mrst_err_count: got %0d want 0", err_count); end
    n_cmp++; if (bus_imm !== 64'd0) begin n_bad++; $display("FAIL mrst_busimm: got %h want 0", bus_imm); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; imm26 = 26'($urandom); ctrl = 3'd0; in_tag = 5'd9; out_ready = 1'b1;
    e = ref_entry(imm26, ctrl, in_tag);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_push_valid: got %b want 1", out_valid); end
    n_cmp++; if (bus_imm !== e.imm) begin n_bad++; $display("FAIL mrst_push_busimm: got %h want %h", bus_imm, e.imm); end
    n_cmp++; if (out_tag !== 5'd9) begin n_bad++; $display("FAIL mrst_push_tag: got %0d want 9", out_tag); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm26 = '0; ctrl = '0; in_tag = '0; merr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_streaming();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
